ecc_36_rd_mon: RTL and testbench

Read-side ECC monitor and output buffer placed directly after the 36-bit SECDED correction stage on the ECC FIFO read path. It registers the corrected read word and its error flags into a 2-entry valid/ready skid buffer. It also keeps saturating single- and double-bit error counters, captures the address and type of the first error, and raises a sticky interrupt for software.

---
 rtl/ecc_36_rd_mon.sv | 188 ++++++++++++++++++
 tb/tb_ecc_36_rd_mon.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_36_rd_mon.sv
// ecc_36_rd_mon: read-side ECC monitor with a 2-entry valid/ready skid buffer,
// saturating single/double-bit error counters, first-error capture and a
// sticky interrupt.
module ecc_36_rd_mon #(
    parameter int                   DATA_WIDTH  = 36,
    parameter int                   ADDR_WIDTH  = 8,
    parameter int                   CNT_WIDTH   = 16,
    parameter logic [CNT_WIDTH-1:0] SBIT_THRESH = 16'd255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sbit_err,
    input  logic                  in_dbit_err,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sbit_err,
    output logic                  out_dbit_err,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic                  err_vld,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_dbit,
    output logic                  irq,
    input  logic                  clr
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state_q, state_d;
    logic   load_head, load_skid, head_from_skid;

    logic [DATA_WIDTH-1:0] skid_data_p1;
    logic                  skid_sbit_p1;
    logic                  skid_dbit_p1;

    logic push, pop;
    logic sbit_p0, dbit_p0;

    logic [CNT_WIDTH-1:0]  sbit_base, dbit_base, sbit_d, dbit_d;
    logic                  vld_base, cap_dbit_base, irq_base;
    logic [ADDR_WIDTH-1:0] addr_base;
    logic                  err_vld_d, err_dbit_d, irq_d;
    logic [ADDR_WIDTH-1:0] err_addr_d;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // A word flagged both ways is treated as an uncorrectable error only.
    assign dbit_p0 = in_dbit_err;
    assign sbit_p0 = in_sbit_err & ~in_dbit_err;

    // Occupancy next-state and which buffer register loads this cycle.
    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        case (state_q)
            EMPTY: if (push) begin
                state_d   = ONE;
                load_head = 1'b1;
            end
            ONE: begin
                if (push && !pop) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (!push && pop) begin
                    state_d = EMPTY;
                end else if (push && pop) begin
                    load_head = 1'b1;
                end
            end
            TWO: if (pop) begin
                state_d        = ONE;
                head_from_skid = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Occupancy register; in_ready/out_valid are registered decodes of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d != TWO);
            out_valid <= (state_d != EMPTY);
        end
    end

    // ---- stage p1: head (output) and skid registers ----
    // Head holds the word on out_*; skid holds the second word while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data     <= '0;
            out_sbit_err <= 1'b0;
            out_dbit_err <= 1'b0;
            skid_data_p1 <= '0;
            skid_sbit_p1 <= 1'b0;
            skid_dbit_p1 <= 1'b0;
        end else begin
            if (load_head) begin
                out_data     <= in_data;
                out_sbit_err <= sbit_p0;
                out_dbit_err <= dbit_p0;
            end else if (head_from_skid) begin
                out_data     <= skid_data_p1;
                out_sbit_err <= skid_sbit_p1;
                out_dbit_err <= skid_dbit_p1;
            end
            if (load_skid) begin
                skid_data_p1 <= in_data;
                skid_sbit_p1 <= sbit_p0;
                skid_dbit_p1 <= dbit_p0;
            end
        end
    end

    // Monitor next-state: clear first, then count/capture the accepted word.
    always_comb begin
        sbit_base     = clr ? '0 : sbit_cnt;
        dbit_base     = clr ? '0 : dbit_cnt;
        vld_base      = clr ? 1'b0 : err_vld;
        cap_dbit_base = clr ? 1'b0 : err_dbit;
        addr_base     = clr ? '0 : err_addr;
        irq_base      = clr ? 1'b0 : irq;

        sbit_d     = sbit_base;
        dbit_d     = dbit_base;
        err_vld_d  = vld_base;
        err_dbit_d = cap_dbit_base;
        err_addr_d = addr_base;
        irq_d      = irq_base;

        if (push && sbit_p0) begin
            sbit_d = sat_inc(sbit_base);
            if (sbit_d == SBIT_THRESH && sbit_base != SBIT_THRESH)
                irq_d = 1'b1;
        end
        if (push && dbit_p0) begin
            dbit_d = sat_inc(dbit_base);
            irq_d  = 1'b1;
        end
        if (push && (sbit_p0 || dbit_p0)) begin
            if (!vld_base) begin
                err_vld_d  = 1'b1;
                err_addr_d = in_addr;
                err_dbit_d = dbit_p0;
            end else if (!cap_dbit_base && dbit_p0) begin
                err_addr_d = in_addr;
                err_dbit_d = 1'b1;
            end
        end
    end

    // Monitor registers: counters, first-error capture and sticky irq.
    always_ff @(posedge clk) begin
        if (rst) begin
            sbit_cnt <= '0;
            dbit_cnt <= '0;
            err_vld  <= 1'b0;
            err_addr <= '0;
            err_dbit <= 1'b0;
            irq      <= 1'b0;
        end else begin
            sbit_cnt <= sbit_d;
            dbit_cnt <= dbit_d;
            err_vld  <= err_vld_d;
            err_addr <= err_addr_d;
            err_dbit <= err_dbit_d;
            irq      <= irq_d;
        end
    end

endmodule

// File: tb/tb_ecc_36_rd_mon.sv
// Directed testbench for ecc_36_rd_mon; a second, narrow-counter instance
// covers counter saturation.
module tb_ecc_36_rd_mon;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [35:0] in_data = '0;
    logic        in_sbit_err = 1'b0;
    logic        in_dbit_err = 1'b0;
    logic [7:0]  in_addr = '0;
    logic        out_ready = 1'b0;
    logic        clr = 1'b0;

    logic        in_ready, out_valid, out_sbit_err, out_dbit_err;
    logic [35:0] out_data;
    logic [15:0] sbit_cnt, dbit_cnt;
    logic        err_vld, err_dbit, irq;
    logic [7:0]  err_addr;

    logic        s_in_ready, s_out_valid, s_out_sbit_err, s_out_dbit_err;
    logic [35:0] s_out_data;
    logic [3:0]  s_sbit_cnt, s_dbit_cnt;
    logic        s_err_vld, s_err_dbit, s_irq;
    logic [7:0]  s_err_addr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ecc_36_rd_mon dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sbit_err(out_sbit_err), .out_dbit_err(out_dbit_err),
        .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
        .err_vld(err_vld), .err_addr(err_addr), .err_dbit(err_dbit),
        .irq(irq), .clr(clr)
    );

    ecc_36_rd_mon #(.CNT_WIDTH(4), .SBIT_THRESH(4'd15)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err), .in_addr(in_addr),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_sbit_err(s_out_sbit_err), .out_dbit_err(s_out_dbit_err),
        .sbit_cnt(s_sbit_cnt), .dbit_cnt(s_dbit_cnt),
        .err_vld(s_err_vld), .err_addr(s_err_addr), .err_dbit(s_err_dbit),
        .irq(s_irq), .clr(clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [35:0] d, input logic [7:0] a,
                         input logic s, input logic db);
        in_valid    = v;
        in_data     = d;
        in_addr     = a;
        in_sbit_err = s;
        in_dbit_err = db;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_hs got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 36'd0 || out_sbit_err !== 1'b0 || out_dbit_err !== 1'b0) $display("FAIL reset_data got %h %b %b want 0 0 0", out_data, out_sbit_err, out_dbit_err);
        else pass_cnt++;
        total_cnt++;
        if (sbit_cnt !== 16'd0 || dbit_cnt !== 16'd0) $display("FAIL reset_cnt got %0d %0d want 0 0", sbit_cnt, dbit_cnt);
        else pass_cnt++;
        total_cnt++;
        if (err_vld !== 1'b0 || err_addr !== 8'd0 || err_dbit !== 1'b0 || irq !== 1'b0) $display("FAIL reset_cap got %b %h %b irq=%b want 0 00 0 0", err_vld, err_addr, err_dbit, irq);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        int bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (in_ready !== 1'b1) bad++;
            drive(1'b1, 36'(i), 8'(i), 1'b0, 1'b0);
            step();
            if (out_valid !== 1'b1 || out_data !== 36'(i)) begin
                $display("FAIL stream_word%0d got vld=%b data=%0d want 1 %0d", i, out_valid, out_data, i);
                bad++;
            end
        end
        drive(1'b0, 36'd0, 8'd0, 1'b0, 1'b0);
        total_cnt++;
        if (bad != 0) $display("FAIL stream_order got %0d bad cycles want 0", bad);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL stream_drain got vld=%b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (sbit_cnt !== 16'd0 || dbit_cnt !== 16'd0 || irq !== 1'b0) $display("FAIL stream_quiet got %0d %0d irq=%b want 0 0 0", sbit_cnt, dbit_cnt, irq);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 36'd1, 8'd1, 1'b0, 1'b0);
        step();
        total_cnt++;
        if (in_ready !== 1'b1 || out_data !== 36'd1) $display("FAIL bp_first got rdy=%b data=%0d want 1 1", in_ready, out_data);
        else pass_cnt++;
        drive(1'b1, 36'd2, 8'd2, 1'b0, 1'b0);
        step();
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_full got rdy=%b want 0", in_ready);
        else pass_cnt++;
        drive(1'b1, 36'd3, 8'd3, 1'b0, 1'b0);
        step();
        total_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 36'd1) $display("FAIL bp_hold got rdy=%b vld=%b data=%0d want 0 1 1", in_ready, out_valid, out_data);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        total_cnt++;
        if (out_data !== 36'd2 || in_ready !== 1'b1) $display("FAIL bp_pop2 got data=%0d rdy=%b want 2 1", out_data, in_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_data !== 36'd3 || out_valid !== 1'b1) $display("FAIL bp_pop3 got data=%0d vld=%b want 3 1", out_data, out_valid);
        else pass_cnt++;
        drive(1'b0, 36'd0, 8'd0, 1'b0, 1'b0);
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_empty got vld=%b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        pulse_clr();
        out_ready = 1'b1;
        drive(1'b1, 36'hA, 8'h12, 1'b1, 1'b0);
        step();
        total_cnt++;
        if (sbit_cnt !== 16'd1 || err_vld !== 1'b1 || err_addr !== 8'h12 || err_dbit !== 1'b0 || irq !== 1'b0)
            $display("FAIL err_sbit1 got cnt=%0d vld=%b addr=%h dbit=%b irq=%b want 1 1 12 0 0", sbit_cnt, err_vld, err_addr, err_dbit, irq);
        else pass_cnt++;
        drive(1'b1, 36'hB, 8'h34, 1'b0, 1'b1);
        step();
        total_cnt++;
        if (dbit_cnt !== 16'd1 || err_addr !== 8'h34 || err_dbit !== 1'b1 || irq !== 1'b1 || out_dbit_err !== 1'b1)
            $display("FAIL err_dbit got cnt=%0d addr=%h dbit=%b irq=%b flag=%b want 1 34 1 1 1", dbit_cnt, err_addr, err_dbit, irq, out_dbit_err);
        else pass_cnt++;
        drive(1'b1, 36'hC, 8'h56, 1'b1, 1'b0);
        step();
        total_cnt++;
        if (sbit_cnt !== 16'd2 || dbit_cnt !== 16'd1 || err_addr !== 8'h34 || err_dbit !== 1'b1 || out_sbit_err !== 1'b1)
            $display("FAIL err_sbit2 got %0d %0d addr=%h dbit=%b flag=%b want 2 1 34 1 1", sbit_cnt, dbit_cnt, err_addr, err_dbit, out_sbit_err);
        else pass_cnt++;
        drive(1'b0, 36'd0, 8'd0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_both_flags();
        drive(1'b1, 36'hD, 8'h99, 1'b1, 1'b1);
        step();
        drive(1'b0, 36'd0, 8'd0, 1'b0, 1'b0);
        total_cnt++;
        if (dbit_cnt !== 16'd2 || sbit_cnt !== 16'd2 || out_sbit_err !== 1'b0 || out_dbit_err !== 1'b1)
            $display("FAIL both_flags got s=%0d d=%0d fs=%b fd=%b want 2 2 0 1", sbit_cnt, dbit_cnt, out_sbit_err, out_dbit_err);
        else pass_cnt++;
        step();
    endtask

    task automatic test_clr_same_cycle();
        clr = 1'b1;
        drive(1'b1, 36'hE, 8'h07, 1'b1, 1'b0);
        step();
        clr = 1'b0;
        drive(1'b0, 36'd0, 8'd0, 1'b0, 1'b0);
        total_cnt++;
        if (sbit_cnt !== 16'd1 || dbit_cnt !== 16'd0 || err_vld !== 1'b1 || err_addr !== 8'h07 || err_dbit !== 1'b0 || irq !== 1'b0)
            $display("FAIL clr_same got s=%0d d=%0d vld=%b addr=%h dbit=%b irq=%b want 1 0 1 07 0 0", sbit_cnt, dbit_cnt, err_vld, err_addr, err_dbit, irq);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 36'hE) $display("FAIL clr_buffer got vld=%b data=%h want 1 e", out_valid, out_data);
        else pass_cnt++;
        step();
    endtask

    task automatic test_thresh();
        pulse_clr();
        out_ready = 1'b1;
        for (int i = 0; i < 254; i++) begin
            drive(1'b1, 36'(i), 8'(i), 1'b1, 1'b0);
            step();
        end
        total_cnt++;
        if (sbit_cnt !== 16'd254 || irq !== 1'b0) $display("FAIL thresh_below got cnt=%0d irq=%b want 254 0", sbit_cnt, irq);
        else pass_cnt++;
        step();
        drive(1'b0, 36'd0, 8'd0, 1'b0, 1'b0);
        total_cnt++;
        if (sbit_cnt !== 16'd255 || irq !== 1'b1) $display("FAIL thresh_hit got cnt=%0d irq=%b want 255 1", sbit_cnt, irq);
        else pass_cnt++;
        step();
    endtask

    task automatic test_saturate();
        pulse_clr();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 36'(i), 8'(i), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 36'd0, 8'd0, 1'b0, 1'b0);
        total_cnt++;
        if (s_sbit_cnt !== 4'd15) $display("FAIL sat_small got %0d want 15", s_sbit_cnt);
        else pass_cnt++;
        total_cnt++;
        if (sbit_cnt !== 16'd20) $display("FAIL sat_wide got %0d want 20", sbit_cnt);
        else pass_cnt++;
        step();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        drive(1'b1, 36'h5, 8'h05, 1'b0, 1'b1);
        step();
        step();
        drive(1'b0, 36'd0, 8'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 36'd0 || out_dbit_err !== 1'b0)
            $display("FAIL midrst_buf got vld=%b rdy=%b data=%h fd=%b want 0 1 0 0", out_valid, in_ready, out_data, out_dbit_err);
        else pass_cnt++;
        total_cnt++;
        if (sbit_cnt !== 16'd0 || dbit_cnt !== 16'd0 || err_vld !== 1'b0 || irq !== 1'b0)
            $display("FAIL midrst_mon got %0d %0d vld=%b irq=%b want 0 0 0 0", sbit_cnt, dbit_cnt, err_vld, irq);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_errors();
        test_both_flags();
        test_clr_same_cycle();
        test_thresh();
        test_saturate();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
